// File: rtl/xpu_txq_slice_sched.sv
// xpu_txq_slice_sched: round-robin tx-queue scheduler gated by per-queue time slices.
//   Grants one eligible queue (queue_req_i & slice_en_i) at a time to the tx core.
//   The grant is acknowledged (tx_ack_i), the frame is transmitted until tx_done_i,
//   and then a programmable inter-frame gap is enforced.
//   Ports:
//     clk, rstn       clock, synchronous active-low reset
//     queue_req_i     per-queue frame-pending flags
//     slice_en_i      per-queue time-slice open flags
//     tx_hold_i       blocks new grants (medium busy / backoff)
//     tx_ack_i        tx core accepted the offered grant (pulse)
//     tx_done_i       tx core finished the current frame (pulse)
//     gap_cycles_i    idle cycles after tx_done_i, sampled on tx_done_i
//     ack_timeout_i   max cycles a grant waits for tx_ack_i, 0 = wait forever
//     grant_valid_o   grant offered to tx core
//     grant_idx_o     queue offered/served, holds last value while idle
//     active_o        granted frame in transmission
//     timeout_evt_o   one-cycle pulse when a grant is abandoned by timeout
//   Build option: define XPU_TXQ_STRICT_PRIO_EN to give queue 0 strict priority.
module xpu_txq_slice_sched #(
    parameter int GAP_WIDTH     = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [3:0]               queue_req_i,
    input  logic [3:0]               slice_en_i,
    input  logic                     tx_hold_i,
    input  logic                     tx_ack_i,
    input  logic                     tx_done_i,
    input  logic [GAP_WIDTH-1:0]     gap_cycles_i,
    input  logic [TIMEOUT_WIDTH-1:0] ack_timeout_i,
    output logic                     grant_valid_o,
    output logic [1:0]               grant_idx_o,
    output logic                     active_o,
    output logic                     timeout_evt_o
);
    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, GAP} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               grant_idx_q, grant_idx_d;
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic [TIMEOUT_WIDTH-1:0] wait_q, wait_d;
    logic [GAP_WIDTH-1:0]     gap_q, gap_d;
    logic                     timeout_evt_q, timeout_evt_d;
    logic [3:0]               eligible;
    logic [1:0]               winner;
    logic [1:0]               rr_adv;

    assign eligible = queue_req_i & slice_en_i;

    // Scanning offsets from high to low leaves the lowest offset from rr_ptr as the winner.
    always_comb begin
        winner = rr_ptr_q;
        for (int i = 3; i >= 0; i--)
            if (eligible[rr_ptr_q + 2'(i)]) winner = rr_ptr_q + 2'(i);
`ifdef XPU_TXQ_STRICT_PRIO_EN
        if (eligible[0]) winner = 2'd0;
`endif
    end

`ifdef XPU_TXQ_STRICT_PRIO_EN
    // Queue 0 sits outside the rotation, so serving it leaves the pointer alone.
    assign rr_adv = (grant_idx_q == 2'd0) ? rr_ptr_q : grant_idx_q + 2'd1;
`else
    assign rr_adv = grant_idx_q + 2'd1;
`endif

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        wait_d        = wait_q;
        gap_d         = gap_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible && !tx_hold_i) begin
                    state_d     = GRANT;
                    grant_idx_d = winner;
                    wait_d      = '0;
                end
            end
            GRANT: begin
                // Acceptance wins over withdrawal, withdrawal over timeout.
                if (tx_ack_i) begin
                    state_d  = ACTIVE;
                    rr_ptr_d = rr_adv;
                end else if (!eligible[grant_idx_q]) begin
                    state_d = IDLE;
                end else if (ack_timeout_i != '0 && wait_q == ack_timeout_i - TIMEOUT_WIDTH'(1)) begin
                    state_d       = IDLE;
                    timeout_evt_d = 1'b1;
                    rr_ptr_d      = rr_adv;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + TIMEOUT_WIDTH'(1);
                end
            end
            ACTIVE: begin
                if (tx_done_i) begin
                    state_d = (gap_cycles_i == '0) ? IDLE : GAP;
                    gap_d   = gap_cycles_i;
                end
            end
            default: begin
                gap_d = gap_q - GAP_WIDTH'(1);
                if (gap_q == GAP_WIDTH'(1)) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            grant_idx_q   <= 2'd0;
            rr_ptr_q      <= 2'd0;
            wait_q        <= '0;
            gap_q         <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_q        <= wait_d;
            gap_q         <= gap_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign grant_valid_o = (state_q == GRANT);
    assign active_o      = (state_q == ACTIVE);
    assign grant_idx_o   = grant_idx_q;
    assign timeout_evt_o = timeout_evt_q;
endmodule
